// File: rtl/relu_layer_ctrl_pkg.sv
// Shared defaults and FSM encoding for the ReLU layer sequencer.
package relu_layer_ctrl_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int ADDR_W_DEF    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/relu_layer_ctrl_if.sv
// Scheduler, SRAM and ReLU-stage signals of the layer sequencer, seen from either side.
interface relu_layer_ctrl_if
  import relu_layer_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
);

  logic                 start;
  logic [ADDR_W:0]      len;
  logic [ADDR_W-1:0]    src_base;
  logic [ADDR_W-1:0]    dst_base;
  logic                 busy;
  logic                 done;
  logic [ADDR_W:0]      clip_cnt;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 relu_di_valid;
  logic [WORD_SIZE-1:0] relu_di;
  logic                 relu_do_valid;
  logic [WORD_SIZE-1:0] relu_do;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;

  modport slave (
    input  start, len, src_base, dst_base, rd_data, relu_do_valid, relu_do,
    output busy, done, clip_cnt, rd_en, rd_addr, relu_di_valid, relu_di,
           wr_en, wr_addr, wr_data
  );

  modport master (
    output start, len, src_base, dst_base, rd_data, relu_do_valid, relu_do,
    input  busy, done, clip_cnt, rd_en, rd_addr, relu_di_valid, relu_di,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/relu_layer_ctrl_addr_gen.sv
// Base+offset address walker: wraps modulo 2^ADDR_W and flags the last of len steps.
module relu_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;

  // Next-state: load restarts the walk, step advances it.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    if (load_i) begin
      addr_d = base_i;
      cnt_d  = {(ADDR_W+1){1'b0}};
      len_d  = len_i;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_ONE;
      cnt_d  = cnt_q + CNT_ONE;
    end else begin
      addr_d = addr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= {ADDR_W{1'b0}};
      cnt_q  <= {(ADDR_W+1){1'b0}};
      len_q  <= {(ADDR_W+1){1'b0}};
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == (len_q - CNT_ONE));

endmodule

// File: rtl/relu_layer_ctrl.sv
// Sequences one ReLU layer pass: SRAM read -> ReLU stage -> SRAM write, counting clipped inputs.
module relu_layer_ctrl
  import relu_layer_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  relu_layer_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_en_q;
  logic                 di_valid_q;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [WORD_SIZE-1:0] wr_data_q;
  logic [ADDR_W:0]      clip_q;

  logic                 accept_s;
  logic                 wr_go_s;
  logic                 rd_last_s;
  logic                 wr_last_s;
  logic [ADDR_W-1:0]    rd_addr_s;
  logic [ADDR_W-1:0]    wr_addr_s;

  // busy_q is still high during the done cycle, so a start there is refused.
  assign accept_s = (state_q == ST_IDLE) && !busy_q && bus.start;
  assign wr_go_s  = bus.relu_do_valid && ((state_q == ST_READ) || (state_q == ST_DRAIN));

  relu_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_s),
    .step_i (rd_en_q),
    .base_i (bus.src_base),
    .len_i  (bus.len),
    .addr_o (rd_addr_s),
    .last_o (rd_last_s)
  );

  relu_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_s),
    .step_i (wr_go_s),
    .base_i (bus.dst_base),
    .len_i  (bus.len),
    .addr_o (wr_addr_s),
    .last_o (wr_last_s)
  );

  // Pass FSM with its registered strobes, write port and clip counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      di_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {WORD_SIZE{1'b0}};
      clip_q     <= {(ADDR_W+1){1'b0}};
    end else begin
      di_valid_q <= rd_en_q;
      done_q     <= 1'b0;
      wr_en_q    <= wr_go_s;
      if (wr_go_s) begin
        wr_addr_q <= wr_addr_s;
        wr_data_q <= bus.relu_do;
      end
      if (di_valid_q && bus.rd_data[WORD_SIZE-1]) begin
        clip_q <= clip_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            busy_q <= 1'b1;
            clip_q <= {(ADDR_W+1){1'b0}};
            if (bus.len != {(ADDR_W+1){1'b0}}) begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= ST_FIN;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_last_s) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wr_go_s && wr_last_s) begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.clip_cnt      = clip_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_s;
  assign bus.relu_di_valid = di_valid_q;
  assign bus.relu_di       = bus.rd_data;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;

endmodule
